// File: rtl/kmc_npr_ctrl_if.sv
// Unibus NPR port of the KMC11 DMA controller. The controller is the master and
// the bus or memory side is the slave.
interface kmc_npr_ctrl_if;
  logic        busREQ;
  logic        busACK;
  logic [17:0] busADDR;
  logic        busWRITE;
  logic        busBYTE;
  logic [15:0] busDATAO;
  logic [15:0] busDATAI;

  modport master (
    output busREQ, busADDR, busWRITE, busBYTE, busDATAO,
    input  busACK, busDATAI
  );

  modport slave (
    input  busREQ, busADDR, busWRITE, busBYTE, busDATAO,
    output busACK, busDATAI
  );
endinterface

// File: rtl/kmc_npr_ctrl.sv
// KMC11 NPR controller: runs one Unibus DMA transfer per NRQ write to NPRC,
// with an acknowledge timeout that reports NXM.
module kmc_npr_ctrl #(
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 kmcMCLR,
  input  logic                 kmcNPRCWR,
  input  logic [7:0]           kmcNPRCIN,
  input  logic [15:0]          kmcNPRIA,
  input  logic [15:0]          kmcNPROA,
  input  logic [15:0]          kmcNPROD,
  output logic [7:0]           kmcNPRC,
  output logic [15:0]          kmcNPRID,
  output logic                 kmcNPRDONE,
  kmc_npr_ctrl_if.master       bus
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [15:0] cnt;
  logic [5:0]  cfg;
  logic        nxm;
  logic        clr;
  logic        start;
  logic        expire;

  // Word transfers (any in-transfer, or an out-transfer without BYTE) are even-aligned.
  function automatic logic [17:0] npr_addr(input logic [7:0] c,
                                           input logic [15:0] ia,
                                           input logic [15:0] oa);
    logic [17:0] a;
    a = c[7] ? {c[5:4], oa} : {c[3:2], ia};
    if (!(c[7] && c[6])) a[0] = 1'b0;
    return a;
  endfunction

  assign clr    = !rst_n || kmcMCLR;
  assign start  = (state == IDLE) && kmcNPRCWR && kmcNPRCIN[0];
  assign expire = (state == REQ) && !bus.busACK && (cnt == CNT_LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = REQ;
      REQ:     if (bus.busACK || cnt == CNT_LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (clr)                                cnt <= '0;
    else if (state == REQ && !bus.busACK)   cnt <= cnt + 16'd1;
    else if (state == DONE)                 cnt <= '0;
  end

  // NPRC is writable only from IDLE; writes during REQ/DONE are dropped entirely.
  always_ff @(posedge clk) begin
    if (clr) begin
      cfg <= '0;
      nxm <= 1'b0;
    end else if (state == IDLE && kmcNPRCWR) begin
      cfg <= kmcNPRCIN[7:2];
      if (kmcNPRCIN[0] || !kmcNPRCIN[1]) nxm <= 1'b0;
    end else if (expire) begin
      nxm <= 1'b1;
    end
  end

  // Bus address, direction and write data are captured once when the request starts.
  always_ff @(posedge clk) begin
    if (clr) begin
      bus.busADDR  <= '0;
      bus.busWRITE <= 1'b0;
      bus.busBYTE  <= 1'b0;
      bus.busDATAO <= '0;
    end else if (start) begin
      bus.busADDR  <= npr_addr(kmcNPRCIN, kmcNPRIA, kmcNPROA);
      bus.busWRITE <= kmcNPRCIN[7];
      bus.busBYTE  <= kmcNPRCIN[7] & kmcNPRCIN[6];
      bus.busDATAO <= kmcNPROD;
    end
  end

  always_ff @(posedge clk) begin
    if (clr)                                          kmcNPRID <= '0;
    else if (state == REQ && bus.busACK && !cfg[5])   kmcNPRID <= bus.busDATAI;
  end

  assign kmcNPRC    = {cfg, nxm, (state == REQ)};
  assign kmcNPRDONE = (state == DONE);
  assign bus.busREQ = (state == REQ);

endmodule

// File: tb/tb_kmc_npr_ctrl.sv
// Directed bench for kmc_npr_ctrl: stimulus pushes expected bus requests and
// completions into queues, a negedge monitor pops and compares them.
module tb_kmc_npr_ctrl;

  typedef struct {
    logic [17:0] addr;
    logic        wr;
    logic        by;
    logic [15:0] dato;
  } req_t;

  typedef struct {
    logic [7:0]  nprc;
    logic [15:0] nprid;
    int          len;
  } done_t;

  logic        clk;
  logic        rst_n;
  logic        kmcMCLR;
  logic        kmcNPRCWR;
  logic [7:0]  kmcNPRCIN;
  logic [15:0] kmcNPRIA;
  logic [15:0] kmcNPROA;
  logic [15:0] kmcNPROD;
  logic [7:0]  kmcNPRC;
  logic [15:0] kmcNPRID;
  logic        kmcNPRDONE;

  kmc_npr_ctrl_if bus ();

  kmc_npr_ctrl #(.TIMEOUT(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .kmcMCLR    (kmcMCLR),
    .kmcNPRCWR  (kmcNPRCWR),
    .kmcNPRCIN  (kmcNPRCIN),
    .kmcNPRIA   (kmcNPRIA),
    .kmcNPROA   (kmcNPROA),
    .kmcNPROD   (kmcNPROD),
    .kmcNPRC    (kmcNPRC),
    .kmcNPRID   (kmcNPRID),
    .kmcNPRDONE (kmcNPRDONE),
    .bus        (bus)
  );

  int    total = 0;
  int    bad   = 0;
  req_t  req_q[$];
  done_t done_q[$];
  req_t  cur;
  done_t dexp;
  int    len = 0;
  logic  req_prev = 1'b0;
  logic  done_prev = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.busREQ) begin
      if (!req_prev) begin
        len = 0;
        chk("req_expected", req_q.size() > 0, 1);
        if (req_q.size() > 0) cur = req_q.pop_front();
      end
      len++;
      chk("busADDR",  bus.busADDR,  cur.addr);
      chk("busWRITE", bus.busWRITE, cur.wr);
      chk("busBYTE",  bus.busBYTE,  cur.by);
      chk("busDATAO", bus.busDATAO, cur.dato);
    end
    if (kmcNPRDONE) begin
      chk("done_width", done_prev, 0);
      chk("done_expected", done_q.size() > 0, 1);
      if (done_q.size() > 0) begin
        dexp = done_q.pop_front();
        chk("done_nprc",  kmcNPRC,  dexp.nprc);
        chk("done_nprid", kmcNPRID, dexp.nprid);
        chk("req_cycles", len,      dexp.len);
      end
    end
    req_prev  = bus.busREQ;
    done_prev = kmcNPRDONE;
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [7:0] v);
    kmcNPRCWR = 1'b1;
    kmcNPRCIN = v;
    cyc(1);
    kmcNPRCWR = 1'b0;
    kmcNPRCIN = 8'h00;
  endtask

  task automatic ack(input int k, input logic [15:0] d);
    cyc(k);
    bus.busACK   = 1'b1;
    bus.busDATAI = d;
    cyc(1);
    bus.busACK   = 1'b0;
    bus.busDATAI = 16'h0000;
  endtask

  task automatic push(input logic [17:0] a, input logic w, input logic b, input logic [15:0] d);
    req_t r;
    r.addr = a; r.wr = w; r.by = b; r.dato = d;
    req_q.push_back(r);
  endtask

  task automatic pushd(input logic [7:0] c, input logic [15:0] id, input int n);
    done_t e;
    e.nprc = c; e.nprid = id; e.len = n;
    done_q.push_back(e);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_nprc"},  kmcNPRC,      0);
    chk({tag, "_nprid"}, kmcNPRID,     0);
    chk({tag, "_done"},  kmcNPRDONE,   0);
    chk({tag, "_req"},   bus.busREQ,   0);
    chk({tag, "_addr"},  bus.busADDR,  0);
    chk({tag, "_write"}, bus.busWRITE, 0);
    chk({tag, "_byte"},  bus.busBYTE,  0);
    chk({tag, "_datao"}, bus.busDATAO, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; kmcMCLR = 1'b0; kmcNPRCWR = 1'b0; kmcNPRCIN = 8'h00;
    kmcNPRIA = 16'h1235; kmcNPROA = 16'h1001; kmcNPROD = 16'h5555;
    bus.busACK = 1'b0; bus.busDATAI = 16'h0000;
    cyc(2);
    check_reset("reset");
    rst_n = 1'b1;
    cyc(1);

    // in-transfer, BA=01, ACK after 3 idle cycles
    push(18'h11234, 1'b0, 1'b0, 16'h5555);
    pushd(8'h04, 16'hBEEF, 4);
    wr(8'h05);
    chk("req_one_cycle_after_write", bus.busREQ, 1);
    ack(3, 16'hBEEF);
    cyc(2);

    // byte out-transfer, immediate ACK; write in the DONE cycle is dropped
    kmcNPROD = 16'h00A5;
    push(18'h21001, 1'b1, 1'b1, 16'h00A5);
    pushd(8'hE0, 16'hBEEF, 1);
    wr(8'hE1);
    ack(0, 16'h1111);
    wr(8'h01);
    chk("done_write_dropped_req", bus.busREQ, 0);
    chk("done_write_dropped_nprc", kmcNPRC, 8'hE0);
    cyc(1);

    // timeout: 8 cycles without ACK
    push(18'h01234, 1'b0, 1'b0, 16'h00A5);
    pushd(8'h02, 16'hBEEF, 8);
    wr(8'h01);
    cyc(9);
    chk("timeout_nxm", kmcNPRC, 8'h02);

    // restart clears NXM; a write during REQ is ignored
    push(18'h01000, 1'b1, 1'b0, 16'h00A5);
    pushd(8'h84, 16'hBEEF, 2);
    wr(8'h85);
    chk("restart_clears_nxm", kmcNPRC, 8'h85);
    wr(8'h81);
    ack(0, 16'h2222);
    cyc(2);

    // ACK on the last timeout cycle wins
    push(18'h01234, 1'b0, 1'b0, 16'h00A5);
    pushd(8'h00, 16'hCAFE, 8);
    wr(8'h01);
    ack(7, 16'hCAFE);
    cyc(2);

    // rst_n mid-transfer
    push(18'h11234, 1'b0, 1'b0, 16'h00A5);
    wr(8'h05);
    cyc(1);
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    check_reset("rstn_mid");
    ack(0, 16'h3333);
    cyc(3);
    chk("rstn_late_ack_nprid", kmcNPRID, 0);

    // kmcMCLR mid-transfer
    push(18'h11234, 1'b0, 1'b0, 16'h00A5);
    wr(8'h05);
    cyc(2);
    kmcMCLR = 1'b1;
    cyc(1);
    kmcMCLR = 1'b0;
    check_reset("mclr_mid");
    ack(0, 16'h4444);
    cyc(3);
    chk("mclr_late_ack_nprid", kmcNPRID, 0);

    // NXM clear/retain in IDLE
    push(18'h01234, 1'b0, 1'b0, 16'h00A5);
    pushd(8'h02, 16'h0000, 8);
    wr(8'h01);
    cyc(9);
    chk("nxm_set", kmcNPRC, 8'h02);
    wr(8'h02);
    chk("nxm_retained", kmcNPRC, 8'h02);
    chk("nxm_retained_no_req", bus.busREQ, 0);
    wr(8'h00);
    chk("nxm_cleared", kmcNPRC, 8'h00);
    chk("nxm_cleared_no_req", bus.busREQ, 0);
    cyc(3);

    chk("req_queue_drained",  req_q.size(),  0);
    chk("done_queue_drained", done_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
